// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_pkg
// Brief    : Shared types and constants for the nibble-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   // Ceiling log2, floored at 1 so a single-nibble counter still has a bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w++;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/carry_skip_adder_4bit.sv
`default_nettype none
// ============================================================================
// Module   : carry_skip_adder_4bit
// Brief    : 4-bit ripple adder whose carry-out bypasses the ripple when all
//            four bits propagate.
// Revision : 1.0 - initial release
// ============================================================================
module carry_skip_adder_4bit (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   always_comb begin
      p    = A ^ B;
      g    = A & B;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      sum  = p ^ c[3:0];
      cout = (&p) ? cin : c[4];
   end

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : WIDTH-bit add/subtract, one nibble per clock through a single
//            4-bit carry-skip slice, with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = clog2(NIBBLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] b_eff;
   logic [3:0]       slice_sum;
   logic             slice_cout;

   carry_skip_adder_4bit u_slice (
      .A    (a_q[3:0]),
      .B    (b_q[3:0]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      b_eff   = sub ? ~b : b;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b_eff;
               carry_d = cin ^ sub;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b_eff[WIDTH-1];
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            carry_d = slice_cout;
            a_d     = a_q >> NIBBLE_W;
            b_d     = b_q >> NIBBLE_W;
            // Result nibbles enter at the top so the LSB nibble ends up at bit 0.
            sum_d   = (sum_q >> NIBBLE_W) | (WIDTH'(slice_sum) << (WIDTH - NIBBLE_W));
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               cout_d  = slice_cout;
               ovf_d   = (a_msb_q == b_msb_q) && (slice_sum[3] != a_msb_q);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Directed self-checking bench for nibble_serial_adder (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        sub;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   int total = 0;
   int bad   = 0;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Accept one operation; returns the edge count (accepting edge = 1) at
   // which out_valid was first seen high.
   task automatic launch(input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic op_sub, input logic op_cin, output int edges);
      @(negedge clk);
      a = op_a; b = op_b; sub = op_sub; cin = op_cin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      edges = 1;
      while (!out_valid && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic op_sub, input logic op_cin,
                         input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
      int edges;
      launch(op_a, op_b, op_sub, op_cin, edges);
      check({tag, "_latency"}, edges, 5);
      check({tag, "_sum"}, sum, e_sum);
      check({tag, "_cout"}, cout, e_cout);
      check({tag, "_ovf"}, ovf, e_ovf);
      @(posedge clk); #1;
      check({tag, "_released"}, out_valid, 0);
      check({tag, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      int edges;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;

      run_op("zero",     16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub_pos",  16'h0005, 16'h0002, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0);
      run_op("sub_neg",  16'h0002, 16'h0005, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0);
      run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      run_op("add_cin",  16'h1234, 16'h0F0F, 1'b0, 1'b1, 16'h2144, 1'b0, 1'b0);
      run_op("sub_cin",  16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

      // Backpressure: result must hold and new operands must be ignored.
      out_ready = 1'b0;
      launch(16'h00F0, 16'h0010, 1'b0, 1'b0, edges);
      check("bp_latency", edges, 5);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1;
         @(posedge clk); #1;
         check("bp_out_valid", out_valid, 1);
         check("bp_sum", sum, 16'h0100);
         check("bp_cout", cout, 0);
         check("bp_ovf", ovf, 0);
         check("bp_in_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);
      run_op("after_bp", 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum", sum, 0);
      check("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check("midrst_no_stale", out_valid, 0);
      end
      run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
